hazard_ctrl_mp: RTL and testbench

- Parametrised hazard controller for the multi-stage MIPS pipeline; sits beside the ID stage and drives enables and flushes for PC, IF/ID, ID/EX and EX/MEM.
- Generalises single-cycle load-use detection:
  - configurable load-result latency;
  - N source operands per instruction;
  - youngest-writer tracking, so a younger non-load writer masks an older pending load;
  - mul/div busy stall, branch flush and global memory stall, with a fixed priority between them;
  - saturating stall performance counter.

---
 rtl/hzd_pkg.sv | 22 ++
 rtl/hzd_src_match.sv | 31 +++
 rtl/hazard_ctrl_mp.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl_mp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hzd_pkg.sv
// Shared types for the hazard controller: stall-cause encoding and
// the writer-pipeline entry layout.
package hzd_pkg;

   // rd is stored at a fixed maximum width so the struct stays
   // parameter-independent; REG_AW must not exceed RD_MAX_W.
   localparam int unsigned RD_MAX_W = 8;

   typedef enum logic [1:0] {
      SC_NONE = 2'b00,
      SC_LU   = 2'b01,
      SC_MD   = 2'b10,
      SC_MEM  = 2'b11
   } stall_cause_e;

   typedef struct packed {
      logic                v;
      logic [RD_MAX_W-1:0] rd;
      logic                is_load;
   } wp_entry_t;

endpackage

// File: rtl/hzd_src_match.sv
// One source operand against the writer pipeline: the youngest matching
// writer decides whether the operand is still waiting on a load.
module hzd_src_match
   import hzd_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned DEPTH  = 1
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              src_valid,
   input  wp_entry_t         wp [DEPTH],
   output logic              hazard
);

   logic found;

   // Entry 0 is youngest; the first hit wins and masks older writers.
   always_comb begin
      hazard = 1'b0;
      found  = 1'b0;
      if (src_valid && (rs != '0)) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && wp[k].v && (wp[k].rd == RD_MAX_W'(rs))) begin
               found  = 1'b1;
               hazard = wp[k].is_load;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_mp.sv
// Hazard controller beside ID: load-use with configurable latency, mul/div
// busy, branch flush and memory stall, plus a saturating stall counter.
module hazard_ctrl_mp
   import hzd_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_src_valid,
   input  logic                      id_wr_en,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_is_load,
   input  logic                      id_uses_md,
   input  logic                      md_busy,
   input  logic                      ex_br_flush,
   input  logic                      mem_stall,
   input  logic                      cnt_clr,
   output logic                      pc_en,
   output logic                      ifid_en,
   output logic                      ifid_flush,
   output logic                      id_flush,
   output logic                      idex_en,
   output logic                      exmem_en,
   output logic [1:0]                stall_cause,
   output logic [CNT_W-1:0]          stall_cnt
);

   wp_entry_t          wp_q [LOAD_LAT];
   wp_entry_t          wp_d [LOAD_LAT];
   logic [NUM_SRC-1:0] src_haz;
   logic               lu_haz;
   logic               md_haz;
   logic               stall_any;
   logic               issue;
   stall_cause_e       cause;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hzd_src_match #(
         .REG_AW (REG_AW),
         .DEPTH  (LOAD_LAT)
      ) u_match (
         .rs        (id_rs[i*REG_AW +: REG_AW]),
         .src_valid (id_src_valid[i]),
         .wp        (wp_q),
         .hazard    (src_haz[i])
      );
   end

   assign lu_haz    = id_valid & (|src_haz);
   assign md_haz    = id_valid & id_uses_md & md_busy;
   assign stall_any = lu_haz | md_haz;
   assign issue     = id_valid & ~stall_any & ~ex_br_flush & ~mem_stall;

   // Fixed priority: memory freeze, then branch squash, then ID stall.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      id_flush   = 1'b0;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      cause      = SC_NONE;
      if (mem_stall) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         cause    = SC_MEM;
      end else if (ex_br_flush) begin
         ifid_flush = 1'b1;
         id_flush   = 1'b1;
      end else if (stall_any) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         id_flush = 1'b1;
         cause    = lu_haz ? SC_LU : SC_MD;
      end
   end

   assign stall_cause = cause;
   assign stall_cnt   = cnt_q;

   always_comb begin
      wp_d = wp_q;
      if (!mem_stall) begin
         for (int unsigned k = 1; k < LOAD_LAT; k++) begin
            wp_d[k] = wp_q[k-1];
         end
         wp_d[0] = '{v:       issue & id_wr_en & (id_rd != '0),
                     rd:      RD_MAX_W'(id_rd),
                     is_load: id_is_load};
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (!mem_stall && !ex_br_flush && stall_any && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned k = 0; k < LOAD_LAT; k++) begin
            wp_q[k] <= '0;
         end
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_mp.sv
// Directed scoreboard bench: three controllers (LOAD_LAT 1, 2, 3) driven
// one at a time, outputs and stall count compared every cycle.
module tb_hazard_ctrl_mp;

   localparam logic [7:0] NORM = 8'b1100_1100;
   localparam logic [7:0] LU   = 8'b0001_1101;
   localparam logic [7:0] MD   = 8'b0001_1110;
   localparam logic [7:0] MEM  = 8'b0000_0011;
   localparam logic [7:0] BR   = 8'b1111_1100;

   typedef struct {
      int unsigned u;
      logic [7:0]  vec;
      logic [31:0] cnt;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic       clk;
   logic       resetn       [3];
   logic       id_valid     [3];
   logic [9:0] id_rs        [3];
   logic [1:0] id_src_valid [3];
   logic       id_wr_en     [3];
   logic [4:0] id_rd        [3];
   logic       id_is_load   [3];
   logic       id_uses_md   [3];
   logic       md_busy      [3];
   logic       ex_br_flush  [3];
   logic       mem_stall    [3];
   logic       cnt_clr      [3];
   logic       pc_en        [3];
   logic       ifid_en      [3];
   logic       ifid_flush   [3];
   logic       id_flush     [3];
   logic       idex_en      [3];
   logic       exmem_en     [3];
   logic [1:0] stall_cause  [3];
   logic [31:0] cnt0;
   logic [2:0]  cnt1;
   logic [31:0] cnt2;

   hazard_ctrl_mp #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(32)) u_l1 (
      .clk(clk), .resetn(resetn[0]), .id_valid(id_valid[0]), .id_rs(id_rs[0]),
      .id_src_valid(id_src_valid[0]), .id_wr_en(id_wr_en[0]), .id_rd(id_rd[0]),
      .id_is_load(id_is_load[0]), .id_uses_md(id_uses_md[0]), .md_busy(md_busy[0]),
      .ex_br_flush(ex_br_flush[0]), .mem_stall(mem_stall[0]), .cnt_clr(cnt_clr[0]),
      .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
      .id_flush(id_flush[0]), .idex_en(idex_en[0]), .exmem_en(exmem_en[0]),
      .stall_cause(stall_cause[0]), .stall_cnt(cnt0));

   hazard_ctrl_mp #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(3)) u_l2 (
      .clk(clk), .resetn(resetn[1]), .id_valid(id_valid[1]), .id_rs(id_rs[1]),
      .id_src_valid(id_src_valid[1]), .id_wr_en(id_wr_en[1]), .id_rd(id_rd[1]),
      .id_is_load(id_is_load[1]), .id_uses_md(id_uses_md[1]), .md_busy(md_busy[1]),
      .ex_br_flush(ex_br_flush[1]), .mem_stall(mem_stall[1]), .cnt_clr(cnt_clr[1]),
      .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
      .id_flush(id_flush[1]), .idex_en(idex_en[1]), .exmem_en(exmem_en[1]),
      .stall_cause(stall_cause[1]), .stall_cnt(cnt1));

   hazard_ctrl_mp #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(32)) u_l3 (
      .clk(clk), .resetn(resetn[2]), .id_valid(id_valid[2]), .id_rs(id_rs[2]),
      .id_src_valid(id_src_valid[2]), .id_wr_en(id_wr_en[2]), .id_rd(id_rd[2]),
      .id_is_load(id_is_load[2]), .id_uses_md(id_uses_md[2]), .md_busy(md_busy[2]),
      .ex_br_flush(ex_br_flush[2]), .mem_stall(mem_stall[2]), .cnt_clr(cnt_clr[2]),
      .pc_en(pc_en[2]), .ifid_en(ifid_en[2]), .ifid_flush(ifid_flush[2]),
      .id_flush(id_flush[2]), .idex_en(idex_en[2]), .exmem_en(exmem_en[2]),
      .stall_cause(stall_cause[2]), .stall_cnt(cnt2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] cnt_of(input int unsigned u);
      case (u)
         0:       return cnt0;
         1:       return {29'd0, cnt1};
         default: return cnt2;
      endcase
   endfunction

   function automatic logic [7:0] outs_of(input int unsigned u);
      return {pc_en[u], ifid_en[u], ifid_flush[u], id_flush[u],
              idex_en[u], exmem_en[u], stall_cause[u]};
   endfunction

   task automatic chk(input int unsigned u, input logic [7:0] v,
                      input logic [31:0] c, input string tag);
      exp_t       e;
      logic [7:0] obs_v;
      logic [31:0] obs_c;
      sb.push_back('{u: u, vec: v, cnt: c, tag: tag});
      #1;
      e     = sb.pop_front();
      obs_v = outs_of(e.u);
      obs_c = cnt_of(e.u);
      n_cmp++;
      assert (obs_v === e.vec) else begin
         n_fail++;
         $error("FAIL %s outputs: got %b want %b", e.tag, obs_v, e.vec);
      end
      n_cmp++;
      assert (obs_c === e.cnt) else begin
         n_fail++;
         $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, obs_c, e.cnt);
      end
   endtask

   task automatic instr(input int unsigned u, input logic v, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [1:0] sv, input logic wr,
                        input logic [4:0] rd, input logic ld);
      id_valid[u]     = v;
      id_rs[u]        = {r1, r0};
      id_src_valid[u] = sv;
      id_wr_en[u]     = wr;
      id_rd[u]        = rd;
      id_is_load[u]   = ld;
   endtask

   task automatic lw(input int unsigned u, input logic [4:0] rd);
      instr(u, 1'b1, 5'd1, 5'd0, 2'b01, 1'b1, rd, 1'b1);
   endtask

   task automatic rdr(input int unsigned u, input logic [4:0] rs);
      instr(u, 1'b1, rs, 5'd0, 2'b01, 1'b1, 5'd10, 1'b0);
   endtask

   task automatic nop(input int unsigned u);
      instr(u, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         resetn[u] = 1'b0;
         nop(u);
         id_uses_md[u]  = 1'b0;
         md_busy[u]     = 1'b0;
         ex_br_flush[u] = 1'b0;
         mem_stall[u]   = 1'b0;
         cnt_clr[u]     = 1'b0;
      end
      tick;
      chk(0, NORM, 0, "rst_l1");
      chk(1, NORM, 0, "rst_l2");
      chk(2, NORM, 0, "rst_l3");
      for (int u = 0; u < 3; u++) resetn[u] = 1'b1;
      tick;

      // LOAD_LAT=1
      lw(0, 5);  chk(0, NORM, 0, "l1_lw");     tick;
      rdr(0, 5); chk(0, LU,   0, "l1_stall");  tick;
      chk(0, NORM, 1, "l1_resume"); tick;
      nop(0);    chk(0, NORM, 1, "l1_idle");   tick;
      instr(0, 1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd0, 1'b1);
      chk(0, NORM, 1, "l1_lw_r0"); tick;
      instr(0, 1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd10, 1'b0);
      chk(0, NORM, 1, "l1_read_r0"); tick;
      lw(0, 6);  chk(0, NORM, 1, "l1_lw6"); tick;
      instr(0, 1'b1, 5'd2, 5'd6, 2'b01, 1'b1, 5'd10, 1'b0);
      chk(0, NORM, 1, "l1_srcmask"); tick;
      lw(0, 5);  chk(0, NORM, 1, "l1_lw5b"); tick;
      instr(0, 1'b1, 5'd1, 5'd5, 2'b11, 1'b1, 5'd10, 1'b0);
      chk(0, LU, 1, "l1_src1"); tick;
      nop(0);    chk(0, NORM, 2, "l1_src1_after"); tick;
      lw(0, 5);  chk(0, NORM, 2, "l1_lw5c"); tick;
      rdr(0, 5); ex_br_flush[0] = 1'b1;
      chk(0, BR, 2, "l1_br_lu"); tick;
      ex_br_flush[0] = 1'b0; nop(0);
      chk(0, NORM, 2, "l1_br_after"); tick;
      lw(0, 5);  chk(0, NORM, 2, "l1_lw5d"); tick;
      rdr(0, 5); id_uses_md[0] = 1'b1; md_busy[0] = 1'b1;
      chk(0, LU, 2, "l1_lu_over_md"); tick;
      nop(0); id_uses_md[0] = 1'b0; md_busy[0] = 1'b0;
      chk(0, NORM, 3, "l1_end"); tick;

      // LOAD_LAT=2, CNT_W=3: mul/div stall, clear, saturation
      instr(1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
      id_uses_md[1] = 1'b1; md_busy[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk(1, MD, 32'(i), "md_run"); tick;
      end
      md_busy[1] = 1'b0;
      chk(1, NORM, 5, "md_cnt5"); tick;
      cnt_clr[1] = 1'b1;
      chk(1, NORM, 5, "md_clr_cyc"); tick;
      cnt_clr[1] = 1'b0;
      chk(1, NORM, 0, "md_cleared"); tick;
      md_busy[1] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk(1, MD, (i > 7) ? 32'd7 : 32'(i), "md_sat_run"); tick;
      end
      md_busy[1] = 1'b0;
      chk(1, NORM, 7, "md_saturated"); tick;
      md_busy[1] = 1'b1; cnt_clr[1] = 1'b1;
      chk(1, MD, 7, "clr_vs_inc"); tick;
      md_busy[1] = 1'b0; cnt_clr[1] = 1'b0; id_uses_md[1] = 1'b0; nop(1);
      chk(1, NORM, 0, "clr_wins"); tick;
      // youngest writer masks the older load
      lw(1, 4); chk(1, NORM, 0, "l2_lw4"); tick;
      instr(1, 1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd4, 1'b0);
      chk(1, NORM, 0, "l2_addu4"); tick;
      rdr(1, 4); chk(1, NORM, 0, "l2_youngest"); tick;
      lw(1, 4);  chk(1, NORM, 0, "l2_lw4b"); tick;
      nop(1);    chk(1, NORM, 0, "l2_gap"); tick;
      rdr(1, 4); chk(1, LU, 0, "l2_dist1"); tick;
      chk(1, NORM, 1, "l2_dist1_done"); tick;
      nop(1); tick;

      // LOAD_LAT=3
      lw(2, 7);  chk(2, NORM, 0, "l3_lw7"); tick;
      rdr(2, 7); chk(2, LU, 0, "l3_s1"); tick;
      chk(2, LU, 1, "l3_s2"); tick;
      chk(2, LU, 2, "l3_s3"); tick;
      chk(2, NORM, 3, "l3_issue"); tick;
      lw(2, 7);  chk(2, NORM, 3, "l3_lw7b"); tick;
      instr(2, 1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd11, 1'b0);
      chk(2, NORM, 3, "l3_indep"); tick;
      rdr(2, 7); chk(2, LU, 3, "l3_d1_s1"); tick;
      chk(2, LU, 4, "l3_d1_s2"); tick;
      chk(2, NORM, 5, "l3_d1_issue"); tick;
      lw(2, 8);  chk(2, NORM, 5, "l3_lw8"); tick;
      rdr(2, 8); chk(2, LU, 5, "l3_m_s1"); tick;
      mem_stall[2] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk(2, MEM, 6, "l3_mem"); tick;
      end
      mem_stall[2] = 1'b0;
      chk(2, LU, 6, "l3_m_s2"); tick;
      chk(2, LU, 7, "l3_m_s3"); tick;
      chk(2, NORM, 8, "l3_m_issue"); tick;
      lw(2, 9);  chk(2, NORM, 8, "l3_lw9"); tick;
      rdr(2, 9); chk(2, LU, 8, "l3_pre_rst");
      resetn[2] = 1'b0;
      chk(2, NORM, 0, "l3_async_rst"); tick;
      resetn[2] = 1'b1; nop(2);
      chk(2, NORM, 0, "l3_post_rst"); tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
